// File: rtl/frame_capture_controller.sv
// -----------------------------------------------------------------------------
// frame_capture_controller
//
// Sequences single-frame captures from the camera pixel reader into the shared
// frame RAM, then hands the RAM over to the colour-recognition processor.
// The controller owns the camera-read enable, multiplexes the single RAM port
// between the camera writer and the processor reader, and pulses a processing
// start once a complete frame has been stored.
//
// Ports
//   i_Clk               system clock
//   i_Reset             asynchronous active-high reset
//   i_Start             capture request, level sampled in IDLE
//   i_Continuous        1 = re-arm automatically after processing
//   i_VS                camera VSYNC, asynchronous to i_Clk
//   i_Cam_Write_Enable  write strobe from the camera pixel reader
//   i_Cam_Address       write address from the camera pixel reader
//   i_Cam_Data          pixel byte from the camera pixel reader
//   i_Proc_Address      read address from the processor
//   i_Proc_Done         processor finished with the frame
//   o_EnableCameraRead  enable to the camera pixel reader
//   o_RAM_Address       RAM address (registered mux)
//   o_RAM_Data          RAM write data (registered mux)
//   o_RAM_Write_Enable  RAM write enable (registered mux)
//   o_Proc_Start        one-cycle pulse, frame ready
//   o_Busy              high in every state except IDLE
//   o_Frame_Count       completed frames, wraps 255 -> 0
//   o_Pixel_Count       writes accepted in the last/current frame
//   o_Overflow          sticky, write attempted beyond MAX_PIXELS
//   o_Timeout           sticky, VSYNC wait exceeded TIMEOUT_CYCLES
//
// State table
//   state      | meaning
//   IDLE       | waiting for i_Start
//   ARM        | waiting for VSYNC high (vertical blanking)
//   WAIT_FRAME | waiting for VSYNC falling edge (start of frame)
//   CAPTURE    | camera enabled, pixel writes routed to RAM
//   HANDOFF    | one cycle, processor start pulse, frame counted
//   PROCESS    | RAM routed to processor, waiting for i_Proc_Done
// -----------------------------------------------------------------------------
module frame_capture_controller #(
  parameter int ADDR_WIDTH     = 15,
  parameter int MAX_PIXELS     = 19200,
  parameter int TIMEOUT_CYCLES = 4000000
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  input  logic                  i_Start,
  input  logic                  i_Continuous,
  input  logic                  i_VS,
  input  logic                  i_Cam_Write_Enable,
  input  logic [ADDR_WIDTH-1:0] i_Cam_Address,
  input  logic [7:0]            i_Cam_Data,
  input  logic [ADDR_WIDTH-1:0] i_Proc_Address,
  input  logic                  i_Proc_Done,
  output logic                  o_EnableCameraRead,
  output logic [ADDR_WIDTH-1:0] o_RAM_Address,
  output logic [7:0]            o_RAM_Data,
  output logic                  o_RAM_Write_Enable,
  output logic                  o_Proc_Start,
  output logic                  o_Busy,
  output logic [7:0]            o_Frame_Count,
  output logic [15:0]           o_Pixel_Count,
  output logic                  o_Overflow,
  output logic                  o_Timeout
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ARM        = 3'd1,
    S_WAIT_FRAME = 3'd2,
    S_CAPTURE    = 3'd3,
    S_HANDOFF    = 3'd4,
    S_PROCESS    = 3'd5
  } state_t;

  localparam int              TW           = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]   TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]     PIX_MAX      = 16'(MAX_PIXELS);

  state_t        state;
  state_t        state_next;
  logic [TW-1:0] timer;
  logic          timeout_hit;

  logic vs_meta;
  logic vs_sync;
  logic vs_prev;
  logic vs_rise;
  logic vs_fall;

  logic timer_done;
  logic write_ok;
  logic clear_frame;

  // VSYNC synchroniser plus one delay stage for edge detection; an edge on the
  // pin is acted on by the state machine three clocks later.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      vs_meta <= 1'b0;
      vs_sync <= 1'b0;
      vs_prev <= 1'b0;
    end else begin
      vs_meta <= i_VS;
      vs_sync <= vs_meta;
      vs_prev <= vs_sync;
    end
  end

  assign vs_rise    = vs_sync & ~vs_prev;
  assign vs_fall    = ~vs_sync & vs_prev;
  assign timer_done = (timer == TIMEOUT_LAST);

  // A write at the pixel limit is refused and only raises the overflow flag.
  assign write_ok = i_Cam_Write_Enable && (o_Pixel_Count < PIX_MAX);

  always_comb begin
    state_next  = state;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_Start) state_next = S_ARM;
      end
      S_ARM: begin
        // Level check rather than edge: the frame must start from blanking.
        if (vs_sync) begin
          state_next = S_WAIT_FRAME;
        end else if (timer_done) begin
          state_next  = S_IDLE;
          timeout_hit = 1'b1;
        end
      end
      S_WAIT_FRAME: begin
        if (vs_fall) begin
          state_next = S_CAPTURE;
        end else if (timer_done) begin
          state_next  = S_IDLE;
          timeout_hit = 1'b1;
        end
      end
      S_CAPTURE: begin
        if (vs_rise) state_next = S_HANDOFF;
      end
      S_HANDOFF: begin
        state_next = S_PROCESS;
      end
      S_PROCESS: begin
        if (i_Proc_Done) state_next = i_Continuous ? S_ARM : S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Per-frame status clears on a fresh start and on an automatic re-arm.
  assign clear_frame = ((state == S_IDLE) && i_Start) ||
                       ((state == S_PROCESS) && (state_next == S_ARM));

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state              <= S_IDLE;
      timer              <= '0;
      o_EnableCameraRead <= 1'b0;
      o_RAM_Address      <= '0;
      o_RAM_Data         <= '0;
      o_RAM_Write_Enable <= 1'b0;
      o_Proc_Start       <= 1'b0;
      o_Busy             <= 1'b0;
      o_Frame_Count      <= '0;
      o_Pixel_Count      <= '0;
      o_Overflow         <= 1'b0;
      o_Timeout          <= 1'b0;
    end else begin
      state <= state_next;

      // Timer restarts on every state change, so ARM and WAIT_FRAME each get
      // a full budget.
      if (state_next != state) begin
        timer <= '0;
      end else if ((state == S_ARM) || (state == S_WAIT_FRAME)) begin
        timer <= timer + 1'b1;
      end

      // Outputs decoded from the next state so they line up with the state
      // register.
      o_EnableCameraRead <= (state_next == S_CAPTURE);
      o_Busy             <= (state_next != S_IDLE);
      o_Proc_Start       <= (state_next == S_HANDOFF);

      if ((state == S_CAPTURE) && (state_next == S_HANDOFF)) begin
        o_Frame_Count <= o_Frame_Count + 8'd1;
      end

      // RAM port mux: inputs sampled in the current state, one clock latency.
      case (state)
        S_CAPTURE: begin
          o_RAM_Address      <= i_Cam_Address;
          o_RAM_Data         <= i_Cam_Data;
          o_RAM_Write_Enable <= write_ok;
        end
        S_PROCESS: begin
          o_RAM_Address      <= i_Proc_Address;
          o_RAM_Data         <= '0;
          o_RAM_Write_Enable <= 1'b0;
        end
        default: begin
          o_RAM_Address      <= '0;
          o_RAM_Data         <= '0;
          o_RAM_Write_Enable <= 1'b0;
        end
      endcase

      if (clear_frame) begin
        o_Pixel_Count <= '0;
        o_Overflow    <= 1'b0;
        o_Timeout     <= 1'b0;
      end else begin
        // Strobes are counted up to and including the VSYNC-rise cycle.
        if ((state == S_CAPTURE) && i_Cam_Write_Enable) begin
          if (write_ok) begin
            o_Pixel_Count <= o_Pixel_Count + 16'd1;
          end else begin
            o_Overflow <= 1'b1;
          end
        end
        if (timeout_hit) begin
          o_Timeout <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_capture_controller.sv
// -----------------------------------------------------------------------------
// tb_frame_capture_controller
//
// Self-checking bench for frame_capture_controller. Frames are described by a
// table of records (strobe count, post-VSYNC strobes, continuous, ignored-event
// pokes, expected pixel count and overflow). Each accepted camera write pushes
// its expected address/data onto a queue; a monitor pops and compares every
// RAM write the design produces. Timeout and reset-mid-capture are written out
// as dedicated sequences.
// -----------------------------------------------------------------------------
module tb_frame_capture_controller;

  localparam int AW      = 15;
  localparam int MAXP    = 19200;
  localparam int TIMEOUT = 1000;

  logic          i_Clk = 1'b0;
  logic          i_Reset;
  logic          i_Start;
  logic          i_Continuous;
  logic          i_VS;
  logic          i_Cam_Write_Enable;
  logic [AW-1:0] i_Cam_Address;
  logic [7:0]    i_Cam_Data;
  logic [AW-1:0] i_Proc_Address;
  logic          i_Proc_Done;
  logic          o_EnableCameraRead;
  logic [AW-1:0] o_RAM_Address;
  logic [7:0]    o_RAM_Data;
  logic          o_RAM_Write_Enable;
  logic          o_Proc_Start;
  logic          o_Busy;
  logic [7:0]    o_Frame_Count;
  logic [15:0]   o_Pixel_Count;
  logic          o_Overflow;
  logic          o_Timeout;

  frame_capture_controller #(
    .ADDR_WIDTH     (AW),
    .MAX_PIXELS     (MAXP),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .i_Clk              (i_Clk),
    .i_Reset            (i_Reset),
    .i_Start            (i_Start),
    .i_Continuous       (i_Continuous),
    .i_VS               (i_VS),
    .i_Cam_Write_Enable (i_Cam_Write_Enable),
    .i_Cam_Address      (i_Cam_Address),
    .i_Cam_Data         (i_Cam_Data),
    .i_Proc_Address     (i_Proc_Address),
    .i_Proc_Done        (i_Proc_Done),
    .o_EnableCameraRead (o_EnableCameraRead),
    .o_RAM_Address      (o_RAM_Address),
    .o_RAM_Data         (o_RAM_Data),
    .o_RAM_Write_Enable (o_RAM_Write_Enable),
    .o_Proc_Start       (o_Proc_Start),
    .o_Busy             (o_Busy),
    .o_Frame_Count      (o_Frame_Count),
    .o_Pixel_Count      (o_Pixel_Count),
    .o_Overflow         (o_Overflow),
    .o_Timeout          (o_Timeout)
  );

  always #5 i_Clk = ~i_Clk;

  typedef struct {
    int n;        // strobes while VSYNC low
    int tail;     // strobes continuing after VSYNC rises (still in CAPTURE)
    bit cont;     // i_Continuous at i_Proc_Done
    bit poke;     // i_Proc_Done in ARM, i_Start in CAPTURE (both ignored)
    int exp_pix;
    bit exp_ovf;
  } frame_vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  wr_t        q[$];
  frame_vec_t vecs[8];
  int         checks      = 0;
  int         errors      = 0;
  int         writes_seen = 0;
  int         ps_count    = 0;
  int         exp_frames  = 0;
  bit         armed       = 0;

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic run_frame(input frame_vec_t v);
    int  w;
    int  pix;
    int  ps_before;
    wr_t e;
    logic [AW-1:0] pa;
    pix         = 0;
    writes_seen = 0;
    ps_before   = ps_count;
    if (!armed) begin
      i_Start = 1'b1;
      tick();
      i_Start = 1'b0;
      chk("start_busy", o_Busy, 1);
      chk("start_clr_overflow", o_Overflow, 0);
      chk("start_clr_timeout", o_Timeout, 0);
      chk("start_clr_pixels", o_Pixel_Count, 0);
    end
    // Blanking phase; the poke drops a done strobe while in ARM.
    i_VS = 1'b1;
    if (v.poke) i_Proc_Done = 1'b1;
    tick();
    i_Proc_Done = 1'b0;
    repeat (99) tick();
    i_VS = 1'b0;
    repeat (3) tick();
    chk("capture_enable", o_EnableCameraRead, 1);
    for (int i = 0; i < v.n + v.tail; i++) begin
      if (i == v.n) i_VS = 1'b1;
      i_Start            = (v.poke && i == 5);
      i_Cam_Write_Enable = 1'b1;
      i_Cam_Address      = AW'(i);
      i_Cam_Data         = 8'($urandom);
      if (pix < MAXP) begin
        e.addr = i_Cam_Address;
        e.data = i_Cam_Data;
        q.push_back(e);
        pix++;
      end
      tick();
    end
    i_Start = 1'b0;
    // With a tail the strobe is left high one more cycle: it lands in HANDOFF
    // and must not reach the RAM.
    if (v.tail == 0) begin
      i_Cam_Write_Enable = 1'b0;
      i_VS               = 1'b1;
    end
    w = 0;
    while (!o_Proc_Start && w < 10) begin
      tick();
      w++;
    end
    chk("proc_start_seen", o_Proc_Start, 1);
    exp_frames = (exp_frames + 1) % 256;
    chk("frame_count", o_Frame_Count, exp_frames);
    chk("pixel_count", o_Pixel_Count, v.exp_pix);
    chk("overflow", o_Overflow, v.exp_ovf);
    chk("handoff_enable_off", o_EnableCameraRead, 0);
    chk("handoff_busy", o_Busy, 1);
    tick();
    i_Cam_Write_Enable = 1'b0;
    chk("proc_start_width", o_Proc_Start, 0);
    chk("proc_start_pulses", ps_count - ps_before, 1);
    chk("ram_writes", writes_seen, v.exp_pix);
    chk("queue_drained", q.size(), 0);
    for (int j = 0; j < 5; j++) begin
      pa             = AW'($urandom);
      i_Proc_Address = pa;
      tick();
      chk("proc_addr_follow", o_RAM_Address, pa);
      chk("proc_we_low", o_RAM_Write_Enable, 0);
      chk("proc_data_zero", o_RAM_Data, 0);
    end
    i_Continuous = v.cont;
    i_Proc_Done  = 1'b1;
    tick();
    i_Proc_Done = 1'b0;
    chk("done_busy", o_Busy, v.cont);
    if (v.cont) chk("rearm_clr_pixels", o_Pixel_Count, 0);
    armed = v.cont;
    tick();
    chk("after_proc_addr_zero", o_RAM_Address, 0);
  endtask

  initial begin
    int n;
    int ps_before;

    //            n      tail cont poke exp_pix exp_ovf
    vecs[0] = '{19200, 0,   0,   0,   19200,  0};
    vecs[1] = '{19205, 0,   0,   0,   19200,  1};
    vecs[2] = '{40,    3,   0,   0,   43,     0};
    vecs[3] = '{0,     0,   0,   0,   0,      0};
    vecs[4] = '{20,    0,   1,   1,   20,     0};
    vecs[5] = '{30,    3,   1,   0,   33,     0};
    vecs[6] = '{10,    0,   0,   1,   10,     0};
    vecs[7] = '{5,     0,   0,   0,   5,      0};

    i_Reset            = 1'b1;
    i_Start            = 1'b0;
    i_Continuous       = 1'b0;
    i_VS               = 1'b0;
    i_Cam_Write_Enable = 1'b0;
    i_Cam_Address      = '0;
    i_Cam_Data         = '0;
    i_Proc_Address     = '0;
    i_Proc_Done        = 1'b0;

    fork
      forever begin
        @(negedge i_Clk);
        if (o_Proc_Start) ps_count++;
        if (o_RAM_Write_Enable) begin
          writes_seen++;
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write actual=write addr %0d expected=no write", o_RAM_Address);
          end else begin
            wr_t e;
            e = q.pop_front();
            chk("ram_addr", o_RAM_Address, e.addr);
            chk("ram_data", o_RAM_Data, e.data);
          end
        end
      end
    join_none

    repeat (3) tick();
    chk("rst_enable", o_EnableCameraRead, 0);
    chk("rst_busy", o_Busy, 0);
    chk("rst_we", o_RAM_Write_Enable, 0);
    chk("rst_frames", o_Frame_Count, 0);
    i_Reset = 1'b0;
    repeat (5) tick();
    chk("idle_busy", o_Busy, 0);

    // Single frame, overflow, tail strobes, empty frame.
    for (int k = 0; k < 4; k++) run_frame(vecs[k]);

    // Timeout with VSYNC held low.
    i_VS = 1'b0;
    repeat (5) tick();
    ps_before = ps_count;
    i_Start   = 1'b1;
    tick();
    i_Start = 1'b0;
    n = 0;
    while (o_Busy && n < 3000) begin
      tick();
      n++;
    end
    chk("timeout_cycles", n, TIMEOUT);
    chk("timeout_flag", o_Timeout, 1);
    chk("timeout_no_start", ps_count - ps_before, 0);
    chk("timeout_frames", o_Frame_Count, exp_frames);

    // Continuous run of three frames with ignored events mixed in.
    for (int k = 4; k < 7; k++) run_frame(vecs[k]);

    // Reset in the middle of a capture.
    i_Start = 1'b1;
    tick();
    i_Start = 1'b0;
    i_VS    = 1'b1;
    repeat (100) tick();
    i_VS = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 500; i++) begin
      wr_t e;
      i_Cam_Write_Enable = 1'b1;
      i_Cam_Address      = AW'(i);
      i_Cam_Data         = 8'($urandom);
      e.addr             = i_Cam_Address;
      e.data             = i_Cam_Data;
      q.push_back(e);
      tick();
    end
    chk("midcap_enable_before", o_EnableCameraRead, 1);
    #2;
    i_Reset = 1'b1;
    #1;
    chk("midrst_enable", o_EnableCameraRead, 0);
    chk("midrst_we", o_RAM_Write_Enable, 0);
    chk("midrst_addr", o_RAM_Address, 0);
    chk("midrst_data", o_RAM_Data, 0);
    chk("midrst_busy", o_Busy, 0);
    chk("midrst_frames", o_Frame_Count, 0);
    chk("midrst_pixels", o_Pixel_Count, 0);
    i_Cam_Write_Enable = 1'b0;
    q.delete();
    exp_frames = 0;
    armed      = 0;
    tick();
    tick();
    i_Reset = 1'b0;
    repeat (20) tick();
    chk("post_rst_idle_busy", o_Busy, 0);
    chk("post_rst_idle_enable", o_EnableCameraRead, 0);

    run_frame(vecs[7]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
